// File: rtl/input_pkg.sv
// Shared types and constants for the input-side interrupt logic.
// Holds the handshake states and the bit positions in irq_source.
package input_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQUEST  = 2'd1,
        ACK_WAIT = 2'd2
    } irq_state_t;

    localparam int IRQ_SRC_KEY    = 0;
    localparam int IRQ_SRC_SWITCH = 1;

endpackage

// File: rtl/lockout_timer.sv
// Down-counting lockout window: start loads LENGTH-1, then it counts down to zero.
// busy is high while the count is nonzero; restarting while busy reloads the count.
module lockout_timer #(
    parameter int LENGTH = 5000000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic start,
    output logic busy
);

    localparam int W = (LENGTH > 2) ? $clog2(LENGTH) : 1;
    localparam logic [W-1:0] LOAD_VALUE = W'(LENGTH - 1);
    localparam logic [W-1:0] ONE        = W'(1);

    logic [W-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (start) begin
            count <= LOAD_VALUE;
        end else if (count != '0) begin
            count <= count - ONE;
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/key_interrupt_controller.sv
// Debounced key and switch event capture, with sticky source flags and a
// four-phase irq_req/irq_ack handshake to the CPU.
//
// state    | meaning
// IDLE     | no request outstanding; waiting for a flag with irq_enable set
// REQUEST  | irq_req asserted; waiting for the CPU to acknowledge
// ACK_WAIT | flags cleared; waiting for the CPU to drop irq_ack
module key_interrupt_controller
    import input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 5000000,
    parameter int COUNT_WIDTH     = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   key_pressed,
    input  logic                   switch_s2,
    input  logic                   irq_enable,
    input  logic                   irq_ack,
    output logic                   irq_req,
    output logic [1:0]             irq_source,
    output logic                   overrun,
    output logic [COUNT_WIDTH-1:0] key_count,
    output logic                   switch_state
);

    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

    irq_state_t state;
    irq_state_t state_next;
    logic       req_next;
    logic       lockout_busy;
    logic       key_accept;
    logic       switch_event;
    logic       ack_clear;
    logic [1:0] source_next;
    logic       overrun_next;

    assign key_accept   = key_pressed & ~lockout_busy;
    assign switch_event = switch_s2 ^ switch_state;
    assign ack_clear    = (state == REQUEST) & irq_ack;

    lockout_timer #(
        .LENGTH (DEBOUNCE_CYCLES)
    ) u_lockout (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (key_accept),
        .busy    (lockout_busy)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            irq_req <= 1'b0;
        end else begin
            state   <= state_next;
            irq_req <= req_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if ((irq_source != 2'b00) && irq_enable) state_next = REQUEST;
            REQUEST:  if (irq_ack) state_next = ACK_WAIT;
            ACK_WAIT: if (!irq_ack) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Registered request: decoded from the next state so it never glitches.
    always_comb begin
        req_next = (state_next == REQUEST);
    end

    // The ack clears first, so an event arriving in the ack cycle survives.
    always_comb begin
        source_next  = ack_clear ? 2'b00 : irq_source;
        overrun_next = ack_clear ? 1'b0 : overrun;
        if (key_accept) begin
            source_next[IRQ_SRC_KEY] = 1'b1;
            if (!ack_clear && irq_source[IRQ_SRC_KEY]) begin
                overrun_next = 1'b1;
            end
        end
        if (switch_event) begin
            source_next[IRQ_SRC_SWITCH] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            irq_source   <= 2'b00;
            overrun      <= 1'b0;
            key_count    <= '0;
            switch_state <= 1'b0;
        end else begin
            irq_source   <= source_next;
            overrun      <= overrun_next;
            switch_state <= switch_s2;
            if (key_accept) begin
                key_count <= key_count + COUNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_key_interrupt_controller.sv
// Bench for key_interrupt_controller: directed vector table, handshake/race
// sequences, counter wrap, async reset abort, and randomized reference-model run.
module tb_key_interrupt_controller;

    localparam int DEB = 4;
    localparam int CW  = 8;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          key_pressed = 1'b0;
    logic          switch_s2 = 1'b0;
    logic          irq_enable = 1'b0;
    logic          irq_ack = 1'b0;
    logic          irq_req;
    logic [1:0]    irq_source;
    logic          overrun;
    logic [CW-1:0] key_count;
    logic          switch_state;

    int checks = 0;
    int errors = 0;

    key_interrupt_controller #(
        .DEBOUNCE_CYCLES (DEB),
        .COUNT_WIDTH     (CW)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .key_pressed  (key_pressed),
        .switch_s2    (switch_s2),
        .irq_enable   (irq_enable),
        .irq_ack      (irq_ack),
        .irq_req      (irq_req),
        .irq_source   (irq_source),
        .overrun      (overrun),
        .key_count    (key_count),
        .switch_state (switch_state)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog expired before the test sequence finished");
        $fatal(1, "watchdog");
    end

    // Reference model: acceptance by elapsed cycles since the last accepted press.
    int            cyc = 0;
    int            last_acc = -100;
    logic          m_req = 1'b0;
    logic          m_wait = 1'b0;
    logic          m_ovr = 1'b0;
    logic          m_sw = 1'b0;
    logic [1:0]    m_src = 2'b00;
    logic [CW-1:0] m_cnt = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_req    = 1'b0;
        m_wait   = 1'b0;
        m_ovr    = 1'b0;
        m_sw     = 1'b0;
        m_src    = 2'b00;
        m_cnt    = '0;
        last_acc = cyc - 100;
    endtask

    task automatic tick();
        logic       acc, swe, clr, n_req, n_wait, n_ovr;
        logic [1:0] n_src;
        acc   = key_pressed && ((cyc - last_acc) >= DEB);
        swe   = (switch_s2 != m_sw);
        clr   = m_req && irq_ack;
        n_src = clr ? 2'b00 : m_src;
        n_src = n_src | {swe, acc};
        n_ovr = clr ? 1'b0 : (m_ovr || (acc && m_src[0]));
        n_req  = m_req;
        n_wait = m_wait;
        if (m_req) begin
            if (irq_ack) begin
                n_req  = 1'b0;
                n_wait = 1'b1;
            end
        end else if (m_wait) begin
            if (!irq_ack) n_wait = 1'b0;
        end else begin
            n_req = (m_src != 2'b00) && irq_enable;
        end
        @(posedge clock);
        #1;
        if (acc) begin
            last_acc = cyc;
            m_cnt    = m_cnt + 1'b1;
        end
        cyc++;
        m_src  = n_src;
        m_ovr  = n_ovr;
        m_req  = n_req;
        m_wait = n_wait;
        m_sw   = switch_s2;
        chk("model_irq_req", irq_req, m_req);
        chk("model_irq_source", irq_source, m_src);
        chk("model_overrun", overrun, m_ovr);
        chk("model_key_count", key_count, m_cnt);
        chk("model_switch_state", switch_state, m_sw);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_irq_req"}, irq_req, 0);
        chk({name, "_irq_source"}, irq_source, 0);
        chk({name, "_overrun"}, overrun, 0);
        chk({name, "_key_count"}, key_count, 0);
        chk({name, "_switch_state"}, switch_state, 0);
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        key_pressed = 1'b0;
        switch_s2   = 1'b0;
        irq_enable  = 1'b0;
        irq_ack     = 1'b0;
        #3;
        model_reset();
        check_all_zero("reset");
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic          key;
        logic          sw;
        logic          en;
        logic          ack;
        logic          e_req;
        logic [1:0]    e_src;
        logic          e_ovr;
        logic [CW-1:0] e_cnt;
        logic          e_sw;
    } vec_t;

    function automatic vec_t mk(input logic key, input logic sw, input logic en, input logic ack,
                                input logic e_req, input logic [1:0] e_src, input logic e_ovr,
                                input logic [CW-1:0] e_cnt, input logic e_sw);
        vec_t v;
        v.key = key; v.sw = sw; v.en = en; v.ack = ack;
        v.e_req = e_req; v.e_src = e_src; v.e_ovr = e_ovr; v.e_cnt = e_cnt; v.e_sw = e_sw;
        return v;
    endfunction

    vec_t vecs[27];

    initial begin
        // Each row: inputs before the edge, expected outputs after it.
        vecs[0]  = mk(1, 0, 1, 0,  0, 2'b01, 0, 1, 0);
        vecs[1]  = mk(0, 0, 1, 0,  1, 2'b01, 0, 1, 0);
        vecs[2]  = mk(1, 0, 1, 0,  1, 2'b01, 0, 1, 0);
        vecs[3]  = mk(1, 0, 1, 0,  1, 2'b01, 0, 1, 0);
        vecs[4]  = mk(0, 0, 1, 0,  1, 2'b01, 0, 1, 0);
        vecs[5]  = mk(1, 0, 1, 0,  1, 2'b01, 1, 2, 0);
        vecs[6]  = mk(0, 0, 1, 1,  0, 2'b00, 0, 2, 0);
        vecs[7]  = mk(0, 0, 1, 1,  0, 2'b00, 0, 2, 0);
        vecs[8]  = mk(0, 0, 1, 1,  0, 2'b00, 0, 2, 0);
        vecs[9]  = mk(0, 0, 1, 0,  0, 2'b00, 0, 2, 0);
        vecs[10] = mk(0, 1, 0, 0,  0, 2'b10, 0, 2, 1);
        vecs[11] = mk(0, 1, 0, 0,  0, 2'b10, 0, 2, 1);
        vecs[12] = mk(0, 1, 1, 0,  1, 2'b10, 0, 2, 1);
        vecs[13] = mk(0, 1, 0, 0,  1, 2'b10, 0, 2, 1);
        vecs[14] = mk(0, 0, 0, 1,  0, 2'b10, 0, 2, 0);
        vecs[15] = mk(0, 0, 0, 1,  0, 2'b10, 0, 2, 0);
        vecs[16] = mk(0, 0, 1, 0,  0, 2'b10, 0, 2, 0);
        vecs[17] = mk(0, 0, 1, 0,  1, 2'b10, 0, 2, 0);
        vecs[18] = mk(0, 0, 1, 1,  0, 2'b00, 0, 2, 0);
        vecs[19] = mk(0, 0, 1, 0,  0, 2'b00, 0, 2, 0);
        vecs[20] = mk(1, 0, 1, 0,  0, 2'b01, 0, 3, 0);
        vecs[21] = mk(0, 0, 1, 0,  1, 2'b01, 0, 3, 0);
        vecs[22] = mk(0, 0, 1, 0,  1, 2'b01, 0, 3, 0);
        vecs[23] = mk(0, 0, 1, 0,  1, 2'b01, 0, 3, 0);
        vecs[24] = mk(1, 0, 1, 1,  0, 2'b01, 0, 4, 0);
        vecs[25] = mk(0, 0, 1, 0,  0, 2'b01, 0, 4, 0);
        vecs[26] = mk(0, 0, 1, 0,  1, 2'b01, 0, 4, 0);

        #2;
        do_reset();

        for (int i = 0; i < 27; i++) begin
            key_pressed = vecs[i].key;
            switch_s2   = vecs[i].sw;
            irq_enable  = vecs[i].en;
            irq_ack     = vecs[i].ack;
            tick();
            chk($sformatf("vec%0d_irq_req", i), irq_req, vecs[i].e_req);
            chk($sformatf("vec%0d_irq_source", i), irq_source, vecs[i].e_src);
            chk($sformatf("vec%0d_overrun", i), overrun, vecs[i].e_ovr);
            chk($sformatf("vec%0d_key_count", i), key_count, vecs[i].e_cnt);
            chk($sformatf("vec%0d_switch_state", i), switch_state, vecs[i].e_sw);
        end
        key_pressed = 1'b0;
        irq_ack     = 1'b0;

        // Counter wrap: 256 accepted presses, request masked throughout.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            key_pressed = 1'b1;
            tick();
            key_pressed = 1'b0;
            for (int j = 0; j < DEB - 1; j++) tick();
            if (i == 254) chk("wrap_count_255", key_count, 8'hFF);
        end
        chk("wrap_count_zero", key_count, 8'h00);
        chk("wrap_overrun", overrun, 1);

        // Reset asserted while a request for both sources is outstanding.
        do_reset();
        key_pressed = 1'b1;
        switch_s2   = 1'b1;
        tick();
        key_pressed = 1'b0;
        irq_enable  = 1'b1;
        tick();
        chk("pre_abort_irq_req", irq_req, 1);
        chk("pre_abort_irq_source", irq_source, 2'b11);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_abort");
        model_reset();
        switch_s2 = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_abort_no_req", irq_req, 0);
        end

        // Randomized run against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            key_pressed = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 9) == 0) switch_s2 = ~switch_s2;
            irq_enable = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) == 0) irq_ack = ~irq_ack;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
